// File: rtl/mac_sched.sv
// Job scheduler for one shared MAC between two requesters: round-robin grant,
// a clear pulse per job, streamed operand beats, pipeline drain, then the result handshake.
module mac_sched #(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned MAC_LAT = 1,
    parameter int unsigned MAX_LEN = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [1:0]       req_last,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    input  logic [ACC_W-1:0] mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_id,
    output logic [7:0]       res_len,
    output logic             res_trunc,
    output logic             busy
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StClear  = 3'd1;
    localparam logic [2:0] StRun    = 3'd2;
    localparam logic [2:0] StDrain  = 3'd3;
    localparam logic [2:0] StResult = 3'd4;

    localparam logic [7:0] MaxLen    = 8'(MAX_LEN);
    localparam logic [2:0] LastDrain = 3'(MAC_LAT - 1);

    logic [2:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       drain_q, drain_d;
    logic             trunc_q, trunc_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic [7:0]       res_len_q, res_len_d;
    logic             res_trunc_q, res_trunc_d;

    logic       own_valid;
    logic       own_last;
    logic [7:0] own_a;
    logic [7:0] own_b;
    logic [7:0] cnt_inc;
    logic       grant;

    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];
    assign own_a     = owner_q ? req_a[15:8] : req_a[7:0];
    assign own_b     = owner_q ? req_b[15:8] : req_b[7:0];
    assign cnt_inc   = cnt_q + 8'd1;
    // rr_q holds the most recently served requester; a tie goes to the other one.
    assign grant     = (&req_valid) ? ~rr_q : req_valid[1];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        trunc_d     = trunc_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_len_d   = res_len_q;
        res_trunc_d = res_trunc_q;
        req_ready   = 2'b00;
        mac_en      = 1'b0;
        mac_a       = 8'd0;
        mac_b       = 8'd0;

        case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    owner_d = grant;
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_d   = 8'd0;
                state_d = StRun;
            end
            StRun: begin
                req_ready = owner_q ? 2'b10 : 2'b01;
                mac_en    = own_valid;
                if (own_valid) begin
                    mac_a = own_a;
                    mac_b = own_b;
                    cnt_d = cnt_inc;
                    // A last flag on the MAX_LEN beat still counts as a normal end.
                    if (own_last || (cnt_inc == MaxLen)) begin
                        trunc_d = ~own_last;
                        drain_d = 3'd0;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) begin
                    res_data_d  = mac_acc;
                    res_id_d    = owner_q;
                    res_len_d   = cnt_q;
                    res_trunc_d = trunc_q;
                    state_d     = StResult;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            StResult: begin
                if (res_ready) begin
                    rr_d    = owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            rr_q        <= 1'b1;
            cnt_q       <= 8'd0;
            drain_q     <= 3'd0;
            trunc_q     <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_len_q   <= 8'd0;
            res_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            trunc_q     <= trunc_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_len_q   <= res_len_d;
            res_trunc_q <= res_trunc_d;
        end
    end

    assign mac_clr   = (state_q == StClear);
    assign busy      = (state_q != StIdle);
    assign res_valid = (state_q == StResult);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_len   = res_len_q;
    assign res_trunc = res_trunc_q;

endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched: two instances (MAX_LEN 255 and 3), a behavioural MAC, directed
// job scenarios and randomized streams checked against a job-level reference model.
module tb_mac_sched;

    localparam int MaxLen0 = 255;
    localparam int MaxLen1 = 3;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       last;
        logic       bub;
    } beat_t;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  len;
        logic        trunc;
    } job_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid [2];
    logic [1:0]  req_ready [2];
    logic [15:0] req_a     [2];
    logic [15:0] req_b     [2];
    logic [1:0]  req_last  [2];
    logic        mac_clr   [2];
    logic        mac_en    [2];
    logic [7:0]  mac_a     [2];
    logic [7:0]  mac_b     [2];
    logic [15:0] acc       [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [15:0] res_data  [2];
    logic        res_id    [2];
    logic [7:0]  res_len   [2];
    logic        res_trunc [2];
    logic        busy      [2];

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    chk_en  = 1'b0;
    logic  clr_prev [2];
    int    clr_cnt  [2];
    beat_t src_q [2][$];
    job_t  exp_q [2][$];
    int    id_log [$];

    always #5 clk = ~clk;

    mac_sched #(.ACC_W(16), .MAC_LAT(1), .MAX_LEN(MaxLen0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_last(req_last[0]),
        .mac_clr(mac_clr[0]), .mac_en(mac_en[0]), .mac_a(mac_a[0]), .mac_b(mac_b[0]),
        .mac_acc(acc[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
        .res_id(res_id[0]), .res_len(res_len[0]), .res_trunc(res_trunc[0]),
        .busy(busy[0])
    );

    mac_sched #(.ACC_W(16), .MAC_LAT(1), .MAX_LEN(MaxLen1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_last(req_last[1]),
        .mac_clr(mac_clr[1]), .mac_en(mac_en[1]), .mac_a(mac_a[1]), .mac_b(mac_b[1]),
        .mac_acc(acc[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
        .res_id(res_id[1]), .res_len(res_len[1]), .res_trunc(res_trunc[1]),
        .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Shared MAC with one cycle of latency, wrapping at 16 bits.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (mac_clr[s]) acc[s] <= 16'd0;
            else if (mac_en[s]) acc[s] <= acc[s] + 16'(mac_a[s]) * 16'(mac_b[s]);
        end
    end

    // Protocol invariants, checked every cycle on both instances.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int s = 0; s < 2; s++) begin
                chk("clr_en_overlap", 64'(mac_clr[s] & mac_en[s]), 64'd0);
                chk("clr_two_cycles", 64'(mac_clr[s] & clr_prev[s]), 64'd0);
                chk("ready_outside_run",
                    64'((|req_ready[s]) & (mac_clr[s] | res_valid[s] | ~busy[s])), 64'd0);
                chk("en_without_valid", 64'(mac_en[s] & ~(|req_valid[s])), 64'd0);
                chk("operands_when_idle", mac_en[s] ? 64'd0 : 64'({mac_a[s], mac_b[s]}), 64'd0);
                clr_prev[s] <= mac_clr[s];
                if (mac_clr[s]) clr_cnt[s] <= clr_cnt[s] + 1;
            end
        end
    end

    task automatic drive_idle(input int s);
        req_valid[s] = 2'b00;
        req_a[s]     = 16'd0;
        req_b[s]     = 16'd0;
        req_last[s]  = 2'b00;
        res_ready[s] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle(0);
        drive_idle(1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_beat(input int r, input int a, input int b, input bit last, input bit bub);
        beat_t bt;
        bt.a = 8'(a); bt.b = 8'(b); bt.last = last; bt.bub = bub;
        src_q[r].push_back(bt);
    endtask

    task automatic push_exp(input int r, input int data, input int len, input bit trunc);
        job_t j;
        j.data = 16'(data); j.len = 8'(len); j.trunc = trunc;
        exp_q[r].push_back(j);
    endtask

    // Reference model: split a requester's beat stream into jobs by last flag or length cap.
    task automatic build_exp(input int r, input int maxlen);
        logic [15:0] sum = 16'd0;
        int          n   = 0;
        for (int k = 0; k < src_q[r].size(); k++) begin
            if (!src_q[r][k].bub) begin
                sum = sum + 16'(src_q[r][k].a) * 16'(src_q[r][k].b);
                n++;
                if (src_q[r][k].last || n == maxlen) begin
                    push_exp(r, int'(sum), n, !src_q[r][k].last);
                    sum = 16'd0;
                    n   = 0;
                end
            end
        end
    endtask

    task automatic gen_random(input int r, input int nbeats);
        for (int k = 0; k < nbeats; k++)
            push_beat(r, $urandom_range(255), $urandom_range(255),
                      (k == nbeats - 1) || ($urandom_range(2) == 0), 1'b0);
    endtask

    // Feeds both source queues into instance s and scores each result against exp_q.
    task automatic run_jobs(input int s, input bit rand_mode, input int budget);
        int         cyc  = 0;
        int         done = 0;
        int         clr0 = clr_cnt[s];
        int         id;
        logic [1:0] fire;
        job_t       e;
        while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
               && cyc < budget) begin
            for (int r = 0; r < 2; r++) begin
                if (src_q[r].size() > 0 && !src_q[r][0].bub
                    && !(rand_mode && $urandom_range(3) == 0)) begin
                    req_valid[s][r]        = 1'b1;
                    req_a[s][8*r +: 8]     = src_q[r][0].a;
                    req_b[s][8*r +: 8]     = src_q[r][0].b;
                    req_last[s][r]         = src_q[r][0].last;
                end else begin
                    req_valid[s][r]        = 1'b0;
                    req_a[s][8*r +: 8]     = 8'd0;
                    req_b[s][8*r +: 8]     = 8'd0;
                    req_last[s][r]         = 1'b0;
                end
            end
            res_ready[s] = rand_mode ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            fire = req_valid[s] & req_ready[s];
            if (res_valid[s] && res_ready[s]) begin
                id = int'(res_id[s]);
                id_log.push_back(id);
                if (exp_q[id].size() == 0) begin
                    chk("unexpected_result", 64'(id), 64'd2);
                end else begin
                    e = exp_q[id].pop_front();
                    chk("res_data", 64'(res_data[s]), 64'(e.data));
                    chk("res_len", 64'(res_len[s]), 64'(e.len));
                    chk("res_trunc", 64'(res_trunc[s]), 64'(e.trunc));
                end
                done++;
            end
            @(posedge clk);
            #1;
            for (int r = 0; r < 2; r++)
                if (src_q[r].size() > 0 && (fire[r] || src_q[r][0].bub)) void'(src_q[r].pop_front());
            cyc++;
        end
        chk("job_timeout", 64'(cyc >= budget), 64'd0);
        drive_idle(s);
        chk("clr_per_job", 64'(clr_cnt[s] - clr0), 64'(done));
        src_q[0].delete(); src_q[1].delete();
        exp_q[0].delete(); exp_q[1].delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int k;
        clr_prev[0] = 1'b0; clr_prev[1] = 1'b0;
        clr_cnt[0]  = 0;    clr_cnt[1]  = 0;
        do_reset();
        chk_en = 1'b1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_busy", 64'(busy[s]), 64'd0);
            chk("reset_res_valid", 64'(res_valid[s]), 64'd0);
            chk("reset_res_fields", 64'({res_data[s], res_id[s], res_len[s], res_trunc[s]}), 64'd0);
        end

        // Four-beat job from requester 0.
        push_beat(0, 3, 2, 0, 0); push_beat(0, 1, 4, 0, 0);
        push_beat(0, 5, 3, 0, 0); push_beat(0, 7, 2, 1, 0);
        push_exp(0, 39, 4, 0);
        run_jobs(0, 0, 200);

        // Both requesters contending from reset: strict alternation starting with 0.
        do_reset();
        id_log.delete();
        for (int j = 0; j < 3; j++) begin
            push_beat(0, 2, 2, 1, 0); push_exp(0, 4, 1, 0);
            push_beat(1, 2, 2, 1, 0); push_exp(1, 4, 1, 0);
        end
        run_jobs(0, 0, 300);
        chk("rr_result_count", 64'(id_log.size()), 64'd6);
        for (int j = 0; j < id_log.size(); j++) chk("rr_order", 64'(id_log[j]), 64'(j % 2));

        // Requester 1 job with two bubble cycles.
        push_beat(1, 1, 1, 0, 0); push_beat(1, 0, 0, 0, 1); push_beat(1, 0, 0, 0, 1);
        push_beat(1, 0, 0, 0, 0); push_beat(1, 1, 1, 1, 0);
        push_exp(1, 2, 3, 0);
        run_jobs(0, 0, 200);

        // Length cap of 3: fourth beat becomes its own job.
        do_reset();
        for (int j = 0; j < 4; j++) push_beat(0, 1, 1, j == 3, 0);
        push_exp(0, 3, 3, 1);
        push_exp(0, 1, 1, 0);
        run_jobs(1, 0, 200);

        // Result held back five cycles, then reset in the middle of the next job.
        do_reset();
        req_valid[0] = 2'b01; req_a[0] = 16'h0002; req_b[0] = 16'h0003; req_last[0] = 2'b01;
        for (k = 0; k < 10 && !req_ready[0][0]; k++) begin @(posedge clk); #1; end
        chk("hold_beat_accepted", 64'(req_ready[0][0]), 64'd1);
        @(posedge clk); #1;
        req_valid[0] = 2'b10; req_a[0] = 16'h0500; req_b[0] = 16'h0500; req_last[0] = 2'b10;
        for (k = 0; k < 10 && !res_valid[0]; k++) begin @(posedge clk); #1; end
        for (int j = 0; j < 5; j++) begin
            chk("hold_valid", 64'(res_valid[0]), 64'd1);
            chk("hold_fields", 64'({res_data[0], res_id[0], res_len[0], res_trunc[0]}),
                64'({16'd6, 1'b0, 8'd1, 1'b0}));
            chk("hold_ready_low", 64'(req_ready[0]), 64'd0);
            @(posedge clk); #1;
        end
        res_ready[0] = 1'b1;
        @(posedge clk); #1;
        res_ready[0] = 1'b0;
        chk("after_hs_idle", 64'({busy[0], res_valid[0]}), 64'd0);
        @(posedge clk); #1;
        chk("next_job_clear", 64'(mac_clr[0]), 64'd1);
        @(posedge clk); #1;
        chk("next_job_run", 64'({req_ready[0], mac_en[0]}), 64'({2'b10, 1'b1}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle(0);
        chk("mid_run_reset_outputs",
            64'({req_ready[0], mac_clr[0], mac_en[0], mac_a[0], mac_b[0], res_valid[0],
                 res_data[0], res_id[0], res_len[0], res_trunc[0], busy[0]}), 64'd0);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            chk("aborted_no_result", 64'({res_valid[0], busy[0]}), 64'd0);
        end

        // Randomized streams, bubbles and back-pressure on both instances.
        for (int it = 0; it < 4; it++) begin
            for (int s = 0; s < 2; s++) begin
                gen_random(0, 12 + $urandom_range(12));
                gen_random(1, 12 + $urandom_range(12));
                build_exp(0, s == 0 ? MaxLen0 : MaxLen1);
                build_exp(1, s == 0 ? MaxLen0 : MaxLen1);
                run_jobs(s, 1, 4000);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
